// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - five-stage pipeline stall/flush control with data-bus timeout; PIPE_CTRL_PERF_EN adds stall_cycles
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        mem_req,
    input  logic        mem_ack,
    input  logic        excp_valid,
    input  logic [31:0] excp_handler,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        mem_busy,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0] stall_cycles,
`endif
    output logic        bus_err
);

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [7:0] wait_cnt, wait_cnt_nx;
    logic       mem_miss;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    always_comb begin
        mem_miss    = 1'b0;
        state_nx    = state;
        wait_cnt_nx = wait_cnt;

        case (state)
            RUN:      mem_miss = mem_req && !mem_ack;
            MEM_WAIT: mem_miss = !mem_ack;
            ERR:      mem_miss = 1'b1;
            default:  mem_miss = 1'b0;
        endcase

        if (excp_valid) begin
            state_nx    = RUN;
            wait_cnt_nx = 8'd0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req && !mem_ack) begin
                        state_nx    = MEM_WAIT;
                        wait_cnt_nx = 8'd1;
                    end
                end
                MEM_WAIT: begin
                    // a dropped mem_req still counts as pending; only ack or timeout leave
                    if (mem_ack) begin
                        state_nx    = RUN;
                        wait_cnt_nx = 8'd0;
                    end else if (wait_cnt == TIMEOUT) begin
                        state_nx    = ERR;
                        wait_cnt_nx = 8'd0;
                    end else begin
                        wait_cnt_nx = wait_cnt + 8'd1;
                    end
                end
                ERR: begin
                    state_nx    = RUN;
                    wait_cnt_nx = 8'd0;
                end
                default: begin
                    state_nx    = RUN;
                    wait_cnt_nx = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        stall  = 6'b000000;
        flush  = 1'b0;
        new_pc = 32'h0;
        if (rst) begin
            if (excp_valid) begin
                flush  = 1'b1;
                new_pc = excp_handler;
            end else if (mem_miss) begin
                stall = 6'b011111;
            end else if (stallreq_ex) begin
                stall = 6'b001111;
            end else if (stallreq_id) begin
                stall = 6'b000111;
            end
        end
    end

    assign mem_busy = rst && (state != RUN);
    assign bus_err  = rst && (state == ERR);

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= 32'd0;
        end else if ((stall != 6'b000000) && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
